// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
//   Groups the run controller's bus-level signals: program load stream,
//   instruction memory write port, core reset, and the snooped core store
//   port.
//   master : controller side (accepts the load stream, drives imem and
//            core_rst, observes the store port).
//   slave  : environment side (load source, imem, core).
// Parameters: XLEN data/address width, AW instruction memory address width.
interface cpu_run_ctrl_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 8
);
  logic            ld_valid;
  logic            ld_ready;
  logic [XLEN-1:0] ld_data;
  logic            ld_last;

  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_wdata;

  logic            core_rst;

  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;

  modport master (
    input  ld_valid, ld_data, ld_last, dmem_we, dmem_addr, dmem_wdata,
    output ld_ready, imem_we, imem_addr, imem_wdata, core_rst
  );

  modport slave (
    output ld_valid, ld_data, ld_last, dmem_we, dmem_addr, dmem_wdata,
    input  ld_ready, imem_we, imem_addr, imem_wdata, core_rst
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Load/reset/run/finish sequencer for the RISC-V core. Streams a program
//   into instruction memory, holds the core in reset for RST_CYCLES cycles,
//   lets it run, and stops on a store to HALT_ADDR or after TIMEOUT cycles.
// Ports:
//   clk_i, rst_ni : clock (rising edge), asynchronous active-low reset
//   start_i       : one-cycle request to begin a sequence (IDLE/DONE only)
//   bus           : cpu_run_ctrl_if.master (load stream, imem write port,
//                   core_rst, snooped store port)
//   busy_o        : sequence in progress (LOAD, HOLD, RUN)
//   done_o        : sequence finished, core frozen in reset
//   pass_o        : halt store carried the value 1
//   timeout_o     : run stopped by the cycle limit
//   load_err_o    : program filled memory without a last beat (truncated)
//   result_o      : data of the halt store
//   cycles_o      : RUN cycles elapsed
// Build option RUN_CTRL_SKIP_LOAD_EN: removes the load path; start goes
//   straight to HOLD and the memory is expected to be preloaded.
module cpu_run_ctrl #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter int unsigned     RST_CYCLES = 1,
  parameter int unsigned     TIMEOUT    = 100,
  parameter logic [XLEN-1:0] HALT_ADDR  = 32'h0000_0FFC,
  parameter int unsigned     AW         = $clog2(IMEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  cpu_run_ctrl_if.master    bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic              load_err_o,
  output logic [XLEN-1:0]   result_o,
  output logic [31:0]       cycles_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned     HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [AW-1:0]   SLOT_LAST = AW'(IMEM_DEPTH - 1);
  localparam logic [31:0]     RUN_LAST  = 32'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] PASS_CODE = XLEN'(1'b1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wcnt_q;
  logic [HW-1:0]   hold_cnt_q;
  logic [31:0]     cycles_q;
  logic            imem_we_q;
  logic [AW-1:0]   imem_addr_q;
  logic [XLEN-1:0] imem_wdata_q;
  logic [XLEN-1:0] result_q;
  logic            pass_q, timeout_q, load_err_q;

  logic accept_s, load_end_s, hold_end_s, halt_s, tmo_s, ld_ready_s;
  logic unused_load_s;

`ifdef RUN_CTRL_SKIP_LOAD_EN
  localparam state_e LAUNCH_ST = ST_HOLD;
  assign accept_s      = 1'b0;
  assign unused_load_s = ^{bus.ld_valid, bus.ld_last, bus.ld_data, ld_ready_s,
                           imem_we_q, load_err_q};
  assign bus.ld_ready  = 1'b0;
  assign bus.imem_we   = 1'b0;
  assign load_err_o    = 1'b0;
`else
  localparam state_e LAUNCH_ST = ST_LOAD;
  assign accept_s      = (state_q == ST_LOAD) && bus.ld_valid;
  assign unused_load_s = 1'b0;
  assign bus.ld_ready  = ld_ready_s;
  assign bus.imem_we   = imem_we_q;
  assign load_err_o    = load_err_q;
`endif

  // The final slot ends the load even without ld_last (flagged as truncated).
  assign load_end_s = accept_s && (bus.ld_last || (wcnt_q == SLOT_LAST));
  assign hold_end_s = (hold_cnt_q == HOLD_LAST);
  assign halt_s     = bus.dmem_we && (bus.dmem_addr == HALT_ADDR);
  assign tmo_s      = (cycles_q == RUN_LAST);

  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign pass_o         = pass_q;
  assign timeout_o      = timeout_q;
  assign result_o       = result_q;
  assign cycles_o       = cycles_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) state_d = LAUNCH_ST;
        else         state_d = state_q;
      end
      ST_LOAD: begin
        if (load_end_s) state_d = ST_HOLD;
        else            state_d = state_q;
      end
      ST_HOLD: begin
        if (hold_end_s) state_d = ST_RUN;
        else            state_d = state_q;
      end
      ST_RUN: begin
        if (halt_s || tmo_s) state_d = ST_DONE;
        else                 state_d = state_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; the core is held in reset everywhere except RUN.
  always_comb begin
    bus.core_rst = 1'b1;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    ld_ready_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.core_rst = 1'b1;
      end
      ST_LOAD: begin
        busy_o     = 1'b1;
        ld_ready_s = 1'b1;
      end
      ST_HOLD: begin
        busy_o = 1'b1;
      end
      ST_RUN: begin
        bus.core_rst = 1'b0;
        busy_o       = 1'b1;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        bus.core_rst = 1'b1;
      end
    endcase
  end

  // Datapath: load counter, imem write port, hold counter, run counter and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q       <= {AW{1'b0}};
      hold_cnt_q   <= {HW{1'b0}};
      cycles_q     <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= {AW{1'b0}};
      imem_wdata_q <= {XLEN{1'b0}};
      result_q     <= {XLEN{1'b0}};
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            wcnt_q     <= {AW{1'b0}};
            hold_cnt_q <= {HW{1'b0}};
            cycles_q   <= 32'd0;
            result_q   <= {XLEN{1'b0}};
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            load_err_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= wcnt_q;
            imem_wdata_q <= bus.ld_data;
            wcnt_q       <= wcnt_q + AW'(1'b1);
            if (!bus.ld_last && (wcnt_q == SLOT_LAST)) begin
              load_err_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_end_s) hold_cnt_q <= {HW{1'b0}};
          else            hold_cnt_q <= hold_cnt_q + HW'(1'b1);
        end
        ST_RUN: begin
          // Halt has priority over the cycle limit in the same cycle.
          if (halt_s) begin
            result_q <= bus.dmem_wdata;
            pass_q   <= (bus.dmem_wdata == PASS_CODE);
          end else if (tmo_s) begin
            timeout_q <= 1'b1;
          end else if (cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
          end
        end
        default: begin
          imem_we_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
//   Directed bench for cpu_run_ctrl (IMEM_DEPTH=4, RST_CYCLES=3, TIMEOUT=100)
//   with a phase-level reference model compared every cycle, plus literal
//   expectations for the key scenarios.
module tb_cpu_run_ctrl;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned RSTC  = 3;
  localparam int unsigned TMO   = 100;
  localparam logic [31:0] HALT  = 32'h0000_0FFC;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout, load_err;
  logic [31:0] result, cycles;

  int checks = 0;
  int fails  = 0;

  cpu_run_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

  cpu_run_ctrl #(
    .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .RST_CYCLES(RSTC), .TIMEOUT(TMO),
    .HALT_ADDR(HALT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .load_err_o(load_err), .result_o(result), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_LOAD, M_HOLD, M_RUN, M_DONE} mphase_t;
  mphase_t       m_ph;
  int            m_words, m_hold_left;
  logic [31:0]   m_cyc, m_res, m_wdata;
  logic [AW-1:0] m_addr;
  bit            m_pass, m_tmo, m_lerr, m_we;

  typedef struct { int a; logic [31:0] d; } wr_t;
  wr_t wr_q[$];

  function automatic void model_reset();
    m_ph = M_IDLE; m_words = 0; m_hold_left = 0; m_cyc = 32'd0; m_res = 32'd0;
    m_wdata = 32'd0; m_addr = '0; m_pass = 0; m_tmo = 0; m_lerr = 0; m_we = 0;
  endfunction

  function automatic void model_step();
    m_we = 0;
    case (m_ph)
      M_IDLE, M_DONE: if (start) begin
        m_ph = M_LOAD; m_words = 0; m_cyc = 32'd0; m_res = 32'd0;
        m_pass = 0; m_tmo = 0; m_lerr = 0;
      end
      M_LOAD: if (bus.ld_valid) begin
        m_we = 1; m_addr = m_words[AW-1:0]; m_wdata = bus.ld_data; m_words++;
        if (bus.ld_last || m_words == DEPTH) begin
          m_lerr = !bus.ld_last; m_ph = M_HOLD; m_hold_left = RSTC;
        end
      end
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) m_ph = M_RUN;
      end
      M_RUN: begin
        if (bus.dmem_we && bus.dmem_addr == HALT) begin
          m_res = bus.dmem_wdata; m_pass = (bus.dmem_wdata == 32'd1); m_ph = M_DONE;
        end else if (m_cyc == 32'(TMO - 1)) begin
          m_tmo = 1; m_ph = M_DONE;
        end else begin
          m_cyc = m_cyc + 32'd1;
        end
      end
      default: ;
    endcase
  endfunction

  // Advance the model on each edge, then compare every output just after it.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    chk("core_rst",   64'(bus.core_rst),   64'(m_ph != M_RUN));
    chk("ld_ready",   64'(bus.ld_ready),   64'(m_ph == M_LOAD));
    chk("imem_we",    64'(bus.imem_we),    64'(m_we));
    chk("imem_addr",  64'(bus.imem_addr),  64'(m_addr));
    chk("imem_wdata", 64'(bus.imem_wdata), 64'(m_wdata));
    chk("busy",       64'(busy),  64'(m_ph == M_LOAD || m_ph == M_HOLD || m_ph == M_RUN));
    chk("done",       64'(done),  64'(m_ph == M_DONE));
    chk("pass",       64'(pass),      64'(m_pass));
    chk("timeout",    64'(timeout),   64'(m_tmo));
    chk("load_err",   64'(load_err),  64'(m_lerr));
    chk("result",     64'(result),    64'(m_res));
    chk("cycles",     64'(cycles),    64'(m_cyc));
    if (bus.imem_we === 1'b1) wr_q.push_back('{int'(bus.imem_addr), bus.imem_wdata});
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    bit got = 0;
    bit rdy;
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    for (int n = 0; n < 8 && !got; n++) begin
      rdy = bus.ld_ready;
      @(negedge clk);
      if (rdy) got = 1;
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("beat_accept", 64'(got), 64'(1'b1));
  endtask

  task automatic wait_run_cycle(input logic [31:0] n);
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (!bus.core_rst && cycles == n) hit = 1;
      else @(negedge clk);
    end
    chk("reach_run_cycle", 64'(hit), 64'(1'b1));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_we = 1'b1; bus.dmem_addr = a; bus.dmem_wdata = d;
    @(negedge clk);
    bus.dmem_we = 1'b0; bus.dmem_addr = 32'd0; bus.dmem_wdata = 32'd0;
  endtask

  logic [31:0] prog [4];
  int n, acc;

  initial begin
    bus.ld_valid = 1'b0; bus.ld_data = 32'd0; bus.ld_last = 1'b0;
    bus.dmem_we = 1'b0; bus.dmem_addr = 32'd0; bus.dmem_wdata = 32'd0;
    prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3; prog[3] = 32'h00000013;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_core_rst", 64'(bus.core_rst), 64'(1'b1));
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'(1'b0));
    chk("rst_busy",     64'(busy),         64'(1'b0));
    chk("rst_cycles",   64'(cycles),       64'(32'd0));
    rst_n = 1'b1;
    @(negedge clk);

    // 4-word load with a bubble, RST_CYCLES hold, halt pass at RUN cycle 20.
    wr_q.delete();
    pulse_start();
    chk("ld_ready_after_start", 64'(bus.ld_ready), 64'(1'b1));
    send_beat(prog[0], 1'b0);
    @(negedge clk);
    send_beat(prog[1], 1'b0);
    send_beat(prog[2], 1'b0);
    send_beat(prog[3], 1'b1);
    chk("load_writes", 64'(wr_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      chk("load_addr", 64'(wr_q[i].a), 64'(i));
      chk("load_data", 64'(wr_q[i].d), 64'(prog[i]));
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.core_rst) break;
      n++;
      @(negedge clk);
    end
    chk("hold_len", 64'(n), 64'(3));
    chk("run_busy", 64'(busy), 64'(1'b1));
    wait_run_cycle(32'd20);
    store(HALT, 32'h1);
    chk("halt_done",     64'(done),         64'(1'b1));
    chk("halt_pass",     64'(pass),         64'(1'b1));
    chk("halt_result",   64'(result),       64'(32'h1));
    chk("halt_cycles",   64'(cycles),       64'(32'd20));
    chk("halt_core_rst", 64'(bus.core_rst), 64'(1'b1));

    // Timeout run with a start pulse during RUN that must be ignored.
    pulse_start();
    send_beat(32'h0000006F, 1'b1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      if (busy && !bus.core_rst) n++;
      start = (n == 10);
      @(negedge clk);
    end
    start = 1'b0;
    chk("tmo_done",       64'(done),    64'(1'b1));
    chk("tmo_flag",       64'(timeout), 64'(1'b1));
    chk("tmo_pass",       64'(pass),    64'(1'b0));
    chk("tmo_cycles",     64'(cycles),  64'(32'd99));
    chk("tmo_run_cycles", 64'(n),       64'(100));

    // Truncated load, non-halt store ignored, halt coinciding with timeout.
    wr_q.delete();
    pulse_start();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 32'h1000 + 32'(i); bus.ld_last = 1'b0;
      if (bus.ld_ready) acc++;
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    chk("trunc_accepted", 64'(acc),          64'(4));
    chk("trunc_ld_ready", 64'(bus.ld_ready), 64'(1'b0));
    chk("trunc_load_err", 64'(load_err),     64'(1'b1));
    chk("trunc_writes",   64'(wr_q.size()),  64'(4));
    wait_run_cycle(32'd5);
    store(32'h0000_0FF8, 32'h1);
    chk("nonhalt_busy", 64'(done), 64'(1'b0));
    wait_run_cycle(32'd99);
    store(HALT, 32'h3);
    chk("tie_done",    64'(done),    64'(1'b1));
    chk("tie_timeout", 64'(timeout), 64'(1'b0));
    chk("tie_pass",    64'(pass),    64'(1'b0));
    chk("tie_result",  64'(result),  64'(32'h3));

    // Reset during RUN, then restart loading from address 0.
    pulse_start();
    send_beat(prog[0], 1'b0);
    send_beat(prog[1], 1'b0);
    send_beat(prog[2], 1'b1);
    wait_run_cycle(32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_core_rst",  64'(bus.core_rst),  64'(1'b1));
    chk("mid_rst_busy",      64'(busy),          64'(1'b0));
    chk("mid_rst_cycles",    64'(cycles),        64'(32'd0));
    chk("mid_rst_imem_addr", 64'(bus.imem_addr), 64'(2'd0));
    chk("mid_rst_wdata",     64'(bus.imem_wdata), 64'(32'd0));
    rst_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
    pulse_start();
    send_beat(32'h00100073, 1'b1);
    chk("restart_writes", 64'(wr_q.size()), 64'(1));
    if (wr_q.size() > 0) begin
      chk("restart_addr", 64'(wr_q[0].a), 64'(0));
      chk("restart_data", 64'(wr_q[0].d), 64'(32'h00100073));
    end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller for the RISC-V core that takes over the load/reset/run/finish sequencing that the bench does today. It streams a program into instruction memory over a valid/ready port, holds the core in reset for a programmable number of cycles, releases it, snoops the core's data-memory store port for a halt write, and enforces a cycle timeout. It sits between the top-level wrapper and the `single_cycle_cpu`/pipeline core, so the same sequence runs in simulation and on FPGA.

## Interface
- `XLEN`, 32: data/address width of core memory ports.
- `IMEM_DEPTH`, 256: instruction memory depth in words; `AW = $clog2(IMEM_DEPTH)`.
- `RST_CYCLES`, 1: cycles `core_rst` stays high after loading (≥1).
- `TIMEOUT`, 100: maximum RUN cycles before forced stop (≥1).
- `HALT_ADDR`, 32'h0000_0FFC: store address that signals end of test.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load/run sequence.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in XLEN, `ld_last` in 1: program load stream.
- `imem_we` out 1, `imem_addr` out AW, `imem_wdata` out XLEN: instruction memory write port.
- `core_rst` out 1: active-high reset to the core.
- `dmem_we` in 1, `dmem_addr` in XLEN, `dmem_wdata` in XLEN: snooped core store port.
- `busy` out 1, `done` out 1, `pass` out 1, `timeout` out 1, `load_err` out 1.
- `result` out XLEN: data of the halt store.
- `cycles` out 32: RUN cycles elapsed.

## Operation
- States: IDLE → LOAD → HOLD → RUN → DONE; DONE → LOAD on `start`.
- IDLE: `core_rst`=1, `ld_ready`=0. `start` → LOAD, clear word counter, `cycles`, all flags.
- LOAD: `ld_ready`=1. Accepted beat (`ld_valid && ld_ready`) writes `ld_data` at word address = counter, counter++. Beat with `ld_last` → HOLD. Beat IMEM_DEPTH accepted without `ld_last` → HOLD with `load_err`=1 (program truncated, still runs).
- HOLD: `core_rst`=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: `core_rst`=0, `cycles`++ each cycle. `dmem_we && dmem_addr==HALT_ADDR` → DONE, `result`=`dmem_wdata`, `pass`=(`dmem_wdata`==1). Else if `cycles`==TIMEOUT-1 → DONE, `timeout`=1.
- DONE: `core_rst`=1 (core frozen), `done`=1, flags and `result`/`cycles` held until next `start`.
- `busy`=1 in LOAD, HOLD, RUN.
- `start` in LOAD/HOLD/RUN ignored. Halt and timeout in same cycle: halt wins, `timeout`=0.
- `cycles` saturates at 2^32-1 (unreachable for TIMEOUT<2^32).

## Timing
- Reset values: state IDLE, `core_rst`=1, `ld_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `load_err`=0, `result`=0, `cycles`=0.
- `ld_ready` is a state decode; rises the cycle after `start` is sampled.
- `imem_we/addr/wdata` registered: one cycle after the accepted beat.
- HOLD entered the cycle after the last beat; `core_rst` falls RST_CYCLES cycles later.
- First RUN cycle shows `cycles`=0; halt sampled on a rising edge → `done`=1 and `core_rst`=1 next cycle.
- Timeout: `done` rises after exactly TIMEOUT RUN cycles; `cycles` reads TIMEOUT-1.
- `rst` low mid-sequence: immediate return to reset values; partially loaded memory content is not cleared.

## Configuration
- `RUN_CTRL_SKIP_LOAD_EN`: when defined, LOAD state and load port logic are compiled out; `start` in IDLE/DONE goes straight to HOLD, `ld_ready`/`imem_we` tied 0, `load_err` tied 0 (memory preloaded by `$readmemh`). Undefined: full load path as above.

## Test plan
- Load 4 words 0x00500093, 0x00A00113, 0x002081B3, last 0x00000013 → `imem_we` pulses at addr 0..3 with those data, HOLD entered after beat 4.
- RST_CYCLES=3: `core_rst` stays 1 exactly 3 cycles after last beat, then 0 with `busy`=1.
- RUN, store 0x1 to 0x0FFC at RUN cycle 20 → `done`=1, `pass`=1, `result`=0x1, `cycles`=20, `core_rst`=1.
- No halt, TIMEOUT=100 → `done`=1, `timeout`=1, `pass`=0, `cycles`=99.
- IMEM_DEPTH=4, 5 beats offered without `ld_last` → 4 accepted, `ld_ready` drops, `load_err`=1; halt store of 0x3 same cycle as timeout → `timeout`=0, `pass`=0, `result`=0x3.
- `rst` low during RUN → all outputs at reset values next edge; `start` then restarts LOAD with `imem_addr`=0.
